// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Serial bit-pattern detector with a runtime-loadable PAT_LEN-bit pattern,
// selectable overlapping / non-overlapping matching, a valid-qualified input
// and a saturating match counter. All outputs come straight from flops.
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   din        in   serial data bit
//   din_valid  in   din is accepted only on edges where this is high
//   overlap    in   1 = overlapping matches, 0 = non-overlapping
//   pat_load   in   load pat_in into the pattern register, clear the window
//   pat_in     in   new pattern (MSB is the first bit expected on the line)
//   cnt_clr    in   synchronous clear of match_cnt (wins over an increment)
//   match      out  one-cycle pulse, the cycle after the last pattern bit
//   match_cnt  out  saturating count of matches
//   fill       out  bits currently counted toward the window (0..PAT_LEN)
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 CNT_W   = 8,
    localparam int                FILL_W  = $clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [FILL_W-1:0]  fill
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_LEN-1:0] sh_reg,    sh_next;
    logic [PAT_LEN-1:0] pat_reg,   pat_next;
    logic [FILL_W-1:0]  fill_reg,  fill_next;
    logic               match_reg, match_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;

    logic [PAT_LEN-1:0] sh_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;

    // Candidate window and fill level if the current bit were accepted.
    // The fill level saturates at PAT_LEN so overlapping mode keeps
    // comparing every new bit against a full window.
    always_comb begin
        sh_shift = {sh_reg[PAT_LEN-2:0], din};
        fill_inc = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
        hit      = din_valid && !pat_load &&
                   (fill_inc == FILL_FULL) && (sh_shift == pat_reg);
    end

    always_comb begin
        sh_next    = sh_reg;
        pat_next   = pat_reg;
        fill_next  = fill_reg;
        match_next = 1'b0;
        cnt_next   = cnt_reg;

        // A pattern load discards the window and drops any bit offered
        // in the same cycle.
        if (pat_load) begin
            pat_next  = pat_in;
            sh_next   = '0;
            fill_next = '0;
        end else if (din_valid) begin
            sh_next    = sh_shift;
            match_next = hit;
            // Non-overlapping: restart the window so the old bits in sh
            // can never contribute to the next match.
            fill_next  = (hit && !overlap) ? '0 : fill_inc;
        end

        if (cnt_clr) begin
            cnt_next = '0;
        end else if (hit && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg    <= '0;
            pat_reg   <= PATTERN;
            fill_reg  <= '0;
            match_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sh_reg    <= sh_next;
            pat_reg   <= pat_next;
            fill_reg  <= fill_next;
            match_reg <= match_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign match     = match_reg;
    assign match_cnt = cnt_reg;
    assign fill      = fill_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Two instances: dut_a with the default configuration (PAT_LEN=4, 1010,
// CNT_W=8) and dut_b (PAT_LEN=2, pattern 11, CNT_W=2) for counter
// saturation. Each driven cycle pushes the model's expected outputs to a
// queue; a monitor pops and compares them just after the clock edge.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut_a signals
    logic       a_din, a_valid, a_ovl, a_load, a_clr;
    logic [3:0] a_pin;
    logic       a_match;
    logic [7:0] a_cnt;
    logic [2:0] a_fill;

    // dut_b signals
    logic       b_din, b_valid, b_ovl, b_load, b_clr;
    logic [1:0] b_pin;
    logic       b_match;
    logic [1:0] b_cnt;
    logic [1:0] b_fill;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_valid),
        .overlap(a_ovl), .pat_load(a_load), .pat_in(a_pin), .cnt_clr(a_clr),
        .match(a_match), .match_cnt(a_cnt), .fill(a_fill)
    );

    seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_valid),
        .overlap(b_ovl), .pat_load(b_load), .pat_in(b_pin), .cnt_clr(b_clr),
        .match(b_match), .match_cnt(b_cnt), .fill(b_fill)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model, one slot per instance.
    int          m_len [2] = '{4, 2};
    int          m_max [2] = '{255, 3};
    logic [15:0] m_rst [2] = '{16'hA, 16'h3};
    logic [15:0] m_pat [2];
    logic [15:0] m_sh  [2];
    int          m_fill[2];
    int          m_cnt [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pat[k]  = m_rst[k];
            m_sh[k]   = '0;
            m_fill[k] = 0;
            m_cnt[k]  = 0;
        end
    endtask

    typedef struct {
        string tag;
        int    which;
        int    match;
        int    cnt;
        int    fill;
    } exp_t;

    exp_t exp_q[$];

    // Drive one cycle on instance `which` (the other idles), update the
    // model and queue the expected post-edge outputs.
    task automatic step(input int which, input string tag, input logic d,
                        input logic v, input logic ovl, input logic ld,
                        input logic [15:0] pin, input logic clr);
        logic [15:0] mask;
        int          hit;
        exp_t        e;
        @(negedge clk);
        a_din = d; a_valid = 1'b0; a_ovl = ovl; a_load = 1'b0; a_clr = 1'b0;
        b_din = d; b_valid = 1'b0; b_ovl = ovl; b_load = 1'b0; b_clr = 1'b0;
        a_pin = pin[3:0];
        b_pin = pin[1:0];
        if (which == 0) begin
            a_valid = v; a_load = ld; a_clr = clr;
        end else begin
            b_valid = v; b_load = ld; b_clr = clr;
        end

        mask = 16'((32'd1 << m_len[which]) - 1);
        hit  = 0;
        if (ld) begin
            m_pat[which]  = pin & mask;
            m_sh[which]   = '0;
            m_fill[which] = 0;
        end else if (v) begin
            m_sh[which] = ((m_sh[which] << 1) | 16'(d)) & mask;
            if (m_fill[which] < m_len[which]) m_fill[which]++;
            hit = (m_fill[which] == m_len[which] &&
                   m_sh[which] == m_pat[which]) ? 1 : 0;
            if (hit != 0 && !ovl) m_fill[which] = 0;
        end
        if (clr) m_cnt[which] = 0;
        else if (hit != 0 && m_cnt[which] < m_max[which]) m_cnt[which]++;

        e.tag = tag; e.which = which; e.match = hit;
        e.cnt = m_cnt[which]; e.fill = m_fill[which];
        exp_q.push_back(e);
    endtask

    // Return to just after the edge that consumed the last step.
    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Scoreboard monitor: compare every queued expectation after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.which == 0) begin
                    check({e.tag, " match"}, int'(a_match), e.match);
                    check({e.tag, " cnt"},   int'(a_cnt),   e.cnt);
                    check({e.tag, " fill"},  int'(a_fill),  e.fill);
                end else begin
                    check({e.tag, " match"}, int'(b_match), e.match);
                    check({e.tag, " cnt"},   int'(b_cnt),   e.cnt);
                    check({e.tag, " fill"},  int'(b_fill),  e.fill);
                end
                $display("txn %s dut%0d exp match=%0d cnt=%0d fill=%0d",
                         e.tag, e.which, e.match, e.cnt, e.fill);
            end
        end
    end

    initial begin
        logic [5:0] s6;
        logic [3:0] s4;

        rst_n = 1'b0;
        a_din = 0; a_valid = 0; a_ovl = 0; a_load = 0; a_clr = 0; a_pin = '0;
        b_din = 0; b_valid = 0; b_ovl = 0; b_load = 0; b_clr = 0; b_pin = '0;
        model_reset();
        #2;
        check("rst a_match", int'(a_match), 0);
        check("rst a_cnt",   int'(a_cnt),   0);
        check("rst a_fill",  int'(a_fill),  0);
        check("rst b_cnt",   int'(b_cnt),   0);
        #10;
        rst_n = 1'b1;

        // Non-overlapping: 101010 -> one match after bit 4
        s6 = 6'b101010;
        for (int i = 5; i >= 0; i--) step(0, "nonovl", s6[i], 1, 0, 0, 0, 0);
        settle();
        check("nonovl end cnt",  int'(a_cnt),  1);
        check("nonovl end fill", int'(a_fill), 2);

        // Overlapping: same stream -> matches after bits 4 and 6
        step(0, "reload", 0, 0, 1, 1, 16'hA, 1);
        for (int i = 5; i >= 0; i--) step(0, "ovl", s6[i], 1, 1, 0, 0, 0);
        settle();
        check("ovl end cnt", int'(a_cnt), 2);

        // Valid gaps with random din in the idle cycles
        step(0, "reload", 0, 0, 0, 1, 16'hA, 1);
        s4 = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            step(0, "gap_bit", s4[i], 1, 0, 0, 0, 0);
            for (int g = 0; g < 2; g++)
                step(0, "gap_idle", 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
        end

        // Pattern load while fill=3, with a valid bit in the same cycle
        for (int i = 0; i < 3; i++) step(0, "pre_load", 1, 1, 0, 0, 0, 0);
        step(0, "load0110", 0, 1, 0, 1, 16'h6, 0);
        settle();
        check("load fill", int'(a_fill), 0);
        s4 = 4'b0110;
        for (int i = 3; i >= 0; i--) step(0, "pat0110", s4[i], 1, 0, 0, 0, 0);
        s4 = 4'b1010;
        for (int i = 3; i >= 0; i--) step(0, "pat_miss", s4[i], 1, 0, 0, 0, 0);

        // Counter saturation on dut_b, then clear coinciding with a hit
        for (int i = 0; i < 6; i++) step(1, "sat", 1, 1, 1, 0, 0, 0);
        settle();
        check("sat cnt", int'(b_cnt), 3);
        step(1, "clr_hit", 1, 1, 1, 0, 0, 1);
        settle();
        check("clr_hit match", int'(b_match), 1);
        check("clr_hit cnt",   int'(b_cnt),   0);

        // Async reset mid-window
        step(0, "win_clear", 0, 0, 0, 1, 16'h6, 0);
        s4 = 4'b0101;
        for (int i = 2; i >= 0; i--) step(0, "pre_rst", s4[i], 1, 0, 0, 0, 0);
        settle();
        rst_n = 1'b0;
        #1;
        check("arst match", int'(a_match), 0);
        check("arst cnt",   int'(a_cnt),   0);
        check("arst fill",  int'(a_fill),  0);
        rst_n = 1'b1;
        model_reset();
        step(0, "post_rst", 0, 1, 0, 0, 0, 0);
        for (int i = 3; i >= 0; i--) step(0, "pat_restored", s4[i] ^ 1'b1, 1, 0, 0, 0, 0);
        settle();
        check("restored cnt", int'(a_cnt), 1);

        step(0, "idle", 0, 0, 0, 0, 0, 0);
        settle();
        check("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector for single-bit input streams. It matches a programmable PAT_LEN-bit pattern and can run in overlapping or non-overlapping mode, selected at runtime. The pattern can be reloaded at runtime, input bits are qualified by a valid strobe, and the block keeps a saturating match counter. It sits between a serial input source and control logic, and supersedes the fixed-pattern, fixed-mode detectors.

## Interface
- PAT_LEN, default 4: pattern length in bits; legal range 2..16.
- PATTERN, default 4'b1010: reset value of the pattern register (PAT_LEN bits). The MSB is the first bit expected on the line.
- CNT_W, default 8: width of the match counter.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  qualifies din; a bit is accepted only on an edge where din_valid=1.
- overlap  input  1  mode select: 1 = overlapping, 0 = non-overlapping. Sampled on every accepted bit.
- pat_load  input  1  loads pat_in into the pattern register.
- pat_in  input  PAT_LEN  new pattern value.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  registered one-cycle pulse per detected pattern (Moore output).
- match_cnt  output  CNT_W  number of matches since reset or the last clear; saturates.
- fill  output  $clog2(PAT_LEN+1)  number of bits currently counted toward a window (0..PAT_LEN).

## Operation
- **Internal state:** shift register sh[PAT_LEN-1:0], fill counter, pattern register pat, match flop, match counter.

- **Accept (din_valid=1, pat_load=0):**
  - sh_n = {sh[PAT_LEN-2:0], din}.
  - fill_n = min(fill+1, PAT_LEN).
  - hit = (fill_n == PAT_LEN) && (sh_n == pat).
  - On the edge: sh <= sh_n and match <= hit.
  - fill <= 0 if (hit && !overlap); otherwise fill <= fill_n.

- **Non-overlapping mode:** after a hit, the next match needs PAT_LEN fresh bits. The old sh contents are ignored because fill is 0.

- **Overlapping mode:** every accepted bit whose last-PAT_LEN window equals pat produces a hit, including back-to-back hits. For example, pattern 11 on input 111 gives hits on bits 2 and 3.

- **Idle (din_valid=0):** sh, fill and pat hold; match <= 0.

- **Pattern load (pat_load=1):**
  - pat <= pat_in, sh <= 0, fill <= 0, match <= 0.
  - Takes priority over din_valid: a bit presented in the same cycle is dropped.

- **Counter:**
  - On a hit, match_cnt <= match_cnt + 1, holding at 2^CNT_W-1 once reached.
  - cnt_clr has priority: if cnt_clr and a hit occur together, match_cnt <= 0, but match still pulses.

- **Mode change mid-stream:** overlap takes effect on the next accepted bit. fill and sh are not disturbed.

- **Reset (rst_n=0, any time):** immediately and asynchronously sets sh=0, fill=0, pat=PATTERN, match=0, match_cnt=0. Any partial window is discarded.

## Timing
- Reset values: match=0, match_cnt=0, fill=0.
- Latency: match goes high in the cycle after the clock edge that accepts the last pattern bit. It is high for exactly one cycle per hit.
- match_cnt and fill update on that same edge, so they are coherent with match.
- Consecutive cycles can both assert match only in overlapping mode, and only with din_valid high in both cycles.
- There are no combinational paths from inputs to outputs; all outputs are flop outputs.
- pat_load and cnt_clr are single-cycle synchronous actions. Holding either high repeats the action every cycle.
- Reset deassertion is synchronised externally. The first accepted bit is the one sampled on the first edge with rst_n=1.

## Test plan
- **Non-overlap:** PATTERN=1010, overlap=0, din 1,0,1,0,1,0 with valid on every bit -> match pulses once, one cycle after the 4th bit; match_cnt=1; fill=2 at the end.
- **Overlap:** same stream with overlap=1 -> match pulses after bit 4 and after bit 6; match_cnt=2.
- **Valid gaps:** 1,0,1,0 with din_valid=0 cycles between bits (din toggling randomly in those cycles) -> exactly one match, one cycle after the 4th valid bit. match stays 0 during the gap cycles.
- **Pattern load:** pat_load with pat_in=0110 while fill=3, din_valid=1 in the same cycle -> fill=0 and that bit is dropped. Stream 0,1,1,0 then gives one match; stream 1,0,1,0 gives none.
- **Counter:** CNT_W=2, overlap=1, pattern 11, din=1 for 6 cycles -> match_cnt climbs to 3 and holds. Then cnt_clr together with a hit -> match_cnt=0 and match=1.
- **Async reset mid-window:** after bits 1,0,1, pulse rst_n low between edges -> outputs clear immediately. A following 0 produces no match; pat returns to PATTERN.
